// File: rtl/execute_mem_sb_drain_ctrl.sv
// Store buffer drain sequencer: writes committed head entries to the dcache or the uncached bus.
// Optional macro EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN adds the stall_cnt output.
module execute_mem_sb_drain_ctrl #(
   parameter int DEPTH = 6,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit_store,
   input  logic             sb_clear,
   input  logic             sb_valid,
   input  logic [31:0]      sb_addr,
   input  logic [3:0]       sb_strb,
   input  logic [31:0]      sb_data,
   input  logic             sb_uncached,
   output logic             sb_wec,
   output logic             dc_req,
   output logic [31:0]      dc_addr,
   output logic [3:0]       dc_strb,
   output logic [31:0]      dc_data,
   input  logic             dc_ready,
   output logic             uc_awvalid,
   input  logic             uc_awready,
   output logic [31:0]      uc_addr,
   output logic [3:0]       uc_wstrb,
   output logic [31:0]      uc_wdata,
   input  logic             uc_bvalid,
   output logic             uc_bready,
   input  logic [1:0]       uc_bresp,
   output logic             err_valid,
   output logic [CNT_W-1:0] pending_cnt,
   output logic             busy,
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
   output logic [31:0]      stall_cnt,
`endif
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      C_REQ  = 3'd1,
      U_REQ  = 3'd2,
      U_RESP = 3'd3,
      POP    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        discard_q;
   logic [31:0] addr_q;
   logic [3:0]  strb_q;
   logic [31:0] data_q;
   logic        start_drain;
   logic        cnt_full;
   logic        cnt_inc;
   logic        cnt_dec;

   // Handshakes: a transfer happens on a cycle where valid and ready are both high;
   // once raised, a valid (dc_req, uc_awvalid) keeps its payload stable until that cycle,
   // except dc_req, which the dcache allows to be withdrawn when the buffer is cleared.
   assign start_drain = (state_q == IDLE) && !sb_clear && (pending_cnt != '0) && sb_valid;
   assign cnt_full    = (pending_cnt == CNT_W'(DEPTH));
   assign cnt_dec     = (state_q == POP);
   assign cnt_inc     = commit_store && (!cnt_full || cnt_dec);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_drain)
               state_d = sb_uncached ? U_REQ : C_REQ;
         end
         C_REQ: begin
            if (sb_clear)
               state_d = IDLE;
            else if (dc_ready)
               state_d = POP;
         end
         U_REQ: begin
            if (uc_awready)
               state_d = U_RESP;
         end
         U_RESP: begin
            // A store flushed while on the bus still finishes its transfer but is not popped.
            if (uc_bvalid)
               state_d = (discard_q || sb_clear) ? IDLE : POP;
         end
         POP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         discard_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == IDLE)
            discard_q <= 1'b0;
         else if (sb_clear && (state_q == U_REQ || state_q == U_RESP))
            discard_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         strb_q <= '0;
         data_q <= '0;
      end else if (start_drain) begin
         addr_q <= sb_addr;
         strb_q <= sb_strb;
         data_q <= sb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pending_cnt <= '0;
      else if (sb_clear)
         pending_cnt <= '0;
      else if (cnt_inc && !cnt_dec)
         pending_cnt <= pending_cnt + CNT_W'(1);
      else if (!cnt_inc && cnt_dec)
         pending_cnt <= pending_cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_valid <= 1'b0;
      else
         err_valid <= (state_q == U_RESP) && uc_bvalid && (uc_bresp != 2'b00);
   end

`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
   logic stall_now;
   assign stall_now = ((state_q == C_REQ) && !dc_ready) ||
                      (state_q == U_REQ) || (state_q == U_RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall_now && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

   assign sb_wec     = (state_q == POP);
   assign dc_req     = (state_q == C_REQ);
   assign uc_awvalid = (state_q == U_REQ);
   assign uc_bready  = (state_q == U_RESP);
   assign busy       = (state_q != IDLE);
   assign dbg_state  = state_q;

   assign dc_addr  = {addr_q[31:2], 2'b00};
   assign dc_strb  = strb_q;
   assign dc_data  = data_q;
   assign uc_addr  = addr_q;
   assign uc_wstrb = strb_q;
   assign uc_wdata = data_q;

`ifndef SYNTHESIS
   // The ROB must never commit more stores than the buffer holds.
   commit_at_full: assert property (@(posedge clk) disable iff (reset)
      !(commit_store && !sb_clear && cnt_full && !cnt_dec));
`endif

endmodule

// File: tb/tb_execute_mem_sb_drain_ctrl.sv
// Directed bench for execute_mem_sb_drain_ctrl: cached/uncached drains, errors, clears, reset.
module tb_execute_mem_sb_drain_ctrl;

   localparam int DEPTH = 6;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             commit_store, sb_clear, sb_valid, sb_uncached;
   logic [31:0]      sb_addr, sb_data;
   logic [3:0]       sb_strb;
   logic             sb_wec, dc_req, dc_ready;
   logic [31:0]      dc_addr, dc_data;
   logic [3:0]       dc_strb;
   logic             uc_awvalid, uc_awready, uc_bvalid, uc_bready;
   logic [31:0]      uc_addr, uc_wdata;
   logic [3:0]       uc_wstrb;
   logic [1:0]       uc_bresp;
   logic             err_valid, busy;
   logic [CNT_W-1:0] pending_cnt;
   logic [2:0]       dbg_state;
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
   logic [31:0]      stall_cnt;
   logic [31:0]      stall_base;
`endif

   int checks = 0;
   int failures = 0;

   execute_mem_sb_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .commit_store(commit_store), .sb_clear(sb_clear),
      .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_strb(sb_strb), .sb_data(sb_data),
      .sb_uncached(sb_uncached), .sb_wec(sb_wec),
      .dc_req(dc_req), .dc_addr(dc_addr), .dc_strb(dc_strb), .dc_data(dc_data),
      .dc_ready(dc_ready),
      .uc_awvalid(uc_awvalid), .uc_awready(uc_awready), .uc_addr(uc_addr),
      .uc_wstrb(uc_wstrb), .uc_wdata(uc_wdata),
      .uc_bvalid(uc_bvalid), .uc_bready(uc_bready), .uc_bresp(uc_bresp),
      .err_valid(err_valid), .pending_cnt(pending_cnt), .busy(busy),
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_head(input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic unc);
      sb_valid    = 1'b1;
      sb_addr     = a;
      sb_strb     = s;
      sb_data     = d;
      sb_uncached = unc;
   endtask

   task automatic idle_inputs;
      commit_store = 1'b0; sb_clear = 1'b0; sb_valid = 1'b0; sb_uncached = 1'b0;
      sb_addr = '0; sb_strb = '0; sb_data = '0;
      dc_ready = 1'b0; uc_awready = 1'b0; uc_bvalid = 1'b0; uc_bresp = 2'b00;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b1;
      #1;
      checks++;
      if ({sb_wec, dc_req, uc_awvalid, uc_bready, err_valid, busy} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {sb_wec, dc_req, uc_awvalid, uc_bready, err_valid, busy});
      end
      checks++;
      if (pending_cnt !== 3'd0 || dc_addr !== 32'h0 || uc_wdata !== 32'h0 || dc_strb !== 4'h0) begin
         failures++;
         $display("FAIL reset_data: cnt=%0d addr=%h data=%h strb=%h want all 0",
                  pending_cnt, dc_addr, uc_wdata, dc_strb);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();
      checks++;
      if (dbg_state !== 3'd0 || pending_cnt !== 3'd0) begin
         failures++;
         $display("FAIL reset_release: state=%0d cnt=%0d want 0/0", dbg_state, pending_cnt);
      end
   endtask

   task automatic test_cached_single;
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
      stall_base = stall_cnt;
`endif
      set_head(32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 1'b0);
      dc_ready = 1'b1; commit_store = 1'b1;
      tick(); commit_store = 1'b0;                          // c1
      checks++;
      if (pending_cnt !== 3'd1 || dc_req !== 1'b0) begin
         failures++;
         $display("FAIL cached_c1: cnt=%0d dc_req=%b want 1/0", pending_cnt, dc_req);
      end
      tick();                                               // c2
      checks++;
      if (dc_req !== 1'b1 || dc_addr !== 32'h0000_1000 || dc_strb !== 4'hF ||
          dc_data !== 32'hDEAD_BEEF || sb_wec !== 1'b0) begin
         failures++;
         $display("FAIL cached_req: req=%b addr=%h strb=%h data=%h wec=%b want 1/1000/f/deadbeef/0",
                  dc_req, dc_addr, dc_strb, dc_data, sb_wec);
      end
      tick(); sb_valid = 1'b0;                              // c3
      checks++;
      if (sb_wec !== 1'b1 || dc_req !== 1'b0) begin
         failures++;
         $display("FAIL cached_pop: wec=%b req=%b want 1/0", sb_wec, dc_req);
      end
      tick();                                               // c4
      checks++;
      if (sb_wec !== 1'b0 || pending_cnt !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL cached_done: wec=%b cnt=%0d busy=%b want 0/0/0", sb_wec, pending_cnt, busy);
      end
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
      checks++;
      if (stall_cnt - stall_base !== 32'd0) begin
         failures++;
         $display("FAIL cached_stall: got %0d want 0", stall_cnt - stall_base);
      end
`endif
   endtask

   task automatic test_uncached_stall;
      int wec_seen;
      wec_seen = 0;
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
      stall_base = stall_cnt;
`endif
      set_head(32'hBFC0_0004, 4'h3, 32'h0000_1234, 1'b1);
      uc_awready = 1'b0; commit_store = 1'b1;
      tick(); commit_store = 1'b0;                          // c1
      for (int c = 2; c <= 5; c++) begin
         tick();
         if (c == 5) uc_awready = 1'b1;
         checks++;
         if (uc_awvalid !== 1'b1 || uc_addr !== 32'hBFC0_0004 || uc_wstrb !== 4'h3 ||
             uc_wdata !== 32'h0000_1234) begin
            failures++;
            $display("FAIL uc_aw_c%0d: valid=%b addr=%h strb=%h data=%h want 1/bfc00004/3/1234",
                     c, uc_awvalid, uc_addr, uc_wstrb, uc_wdata);
         end
      end
      tick(); uc_awready = 1'b0;                            // c6
      checks++;
      if (uc_awvalid !== 1'b0 || uc_bready !== 1'b1) begin
         failures++;
         $display("FAIL uc_resp_wait: awvalid=%b bready=%b want 0/1", uc_awvalid, uc_bready);
      end
      tick(); uc_bvalid = 1'b1; uc_bresp = 2'b00;           // c7
      if (sb_wec === 1'b1) wec_seen++;
      tick(); uc_bvalid = 1'b0; sb_valid = 1'b0;            // c8
      if (sb_wec === 1'b1) wec_seen++;
      checks++;
      if (sb_wec !== 1'b1 || err_valid !== 1'b0) begin
         failures++;
         $display("FAIL uc_pop: wec=%b err=%b want 1/0", sb_wec, err_valid);
      end
      tick();                                               // c9
      if (sb_wec === 1'b1) wec_seen++;
      checks++;
      if (wec_seen != 1 || err_valid !== 1'b0 || pending_cnt !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL uc_done: wec_pulses=%0d err=%b cnt=%0d busy=%b want 1/0/0/0",
                  wec_seen, err_valid, pending_cnt, busy);
      end
`ifdef EXECUTE_MEM_SB_DRAIN_STALL_CNT_EN
      checks++;
      if (stall_cnt - stall_base !== 32'd6) begin
         failures++;
         $display("FAIL uc_stall: got %0d want 6", stall_cnt - stall_base);
      end
`endif
   endtask

   task automatic test_bus_error;
      set_head(32'hBFC0_0010, 4'hF, 32'hCAFE_0001, 1'b1);
      uc_awready = 1'b1; commit_store = 1'b1;
      tick(); commit_store = 1'b0;                          // c1
      tick();                                               // c2: U_REQ accepted
      tick(); uc_awready = 1'b0; uc_bvalid = 1'b1; uc_bresp = 2'b10;  // c3
      tick(); uc_bvalid = 1'b0; uc_bresp = 2'b00; sb_valid = 1'b0;    // c4
      checks++;
      if (sb_wec !== 1'b1 || err_valid !== 1'b1) begin
         failures++;
         $display("FAIL buserr_pulse: wec=%b err=%b want 1/1", sb_wec, err_valid);
      end
      tick();                                               // c5
      checks++;
      if (sb_wec !== 1'b0 || err_valid !== 1'b0 || pending_cnt !== 3'd0) begin
         failures++;
         $display("FAIL buserr_after: wec=%b err=%b cnt=%0d want 0/0/0", sb_wec, err_valid, pending_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      int peak;
      pulses = 0; peak = 0;
      set_head(32'h0000_2000, 4'hF, 32'h5555_AAAA, 1'b0);
      dc_ready = 1'b1;
      for (int i = 0; i < 26; i++) begin
         commit_store = (i < 6);
         tick();                                            // now cycle i+1
         if (sb_wec === 1'b1) pulses++;
         if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
         if (i + 1 == 3) begin
            checks++;
            if (pending_cnt !== 3'd3 || sb_wec !== 1'b1) begin
               failures++;
               $display("FAIL b2b_c3: cnt=%0d wec=%b want 3/1", pending_cnt, sb_wec);
            end
         end
         if (i + 1 == 4) begin
            checks++;
            if (pending_cnt !== 3'd3) begin
               failures++;
               $display("FAIL b2b_commit_with_pop: cnt=%0d want 3", pending_cnt);
            end
         end
      end
      commit_store = 1'b0; sb_valid = 1'b0;
      checks++;
      if (pulses != 6 || peak != 5 || pending_cnt !== 3'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_total: pulses=%0d peak=%0d cnt=%0d busy=%b want 6/5/0/0",
                  pulses, peak, pending_cnt, busy);
      end
   endtask

   task automatic test_clear_cached;
      set_head(32'h0000_2003, 4'h1, 32'h0000_00AB, 1'b0);
      dc_ready = 1'b0; commit_store = 1'b1;
      tick(); commit_store = 1'b0;                          // c1
      tick(); sb_clear = 1'b1;                              // c2
      checks++;
      if (dc_req !== 1'b1 || dc_addr !== 32'h0000_2000) begin
         failures++;
         $display("FAIL clr_c_req: req=%b addr=%h want 1/2000", dc_req, dc_addr);
      end
      tick(); sb_clear = 1'b0; sb_valid = 1'b0;             // c3
      checks++;
      if (dc_req !== 1'b0 || busy !== 1'b0 || pending_cnt !== 3'd0 || sb_wec !== 1'b0) begin
         failures++;
         $display("FAIL clr_c_drop: req=%b busy=%b cnt=%0d wec=%b want 0/0/0/0",
                  dc_req, busy, pending_cnt, sb_wec);
      end
   endtask

   task automatic test_clear_uncached;
      int wec_seen;
      wec_seen = 0;
      set_head(32'hBFC0_0020, 4'hF, 32'h0BAD_F00D, 1'b1);
      uc_awready = 1'b0; commit_store = 1'b1;
      tick(); commit_store = 1'b0;                          // c1
      tick(); sb_clear = 1'b1;                              // c2: U_REQ
      tick(); sb_clear = 1'b0;                              // c3
      if (sb_wec === 1'b1) wec_seen++;
      checks++;
      if (uc_awvalid !== 1'b1 || pending_cnt !== 3'd0 || uc_addr !== 32'hBFC0_0020) begin
         failures++;
         $display("FAIL clr_u_hold: awvalid=%b cnt=%0d addr=%h want 1/0/bfc00020",
                  uc_awvalid, pending_cnt, uc_addr);
      end
      tick(); uc_awready = 1'b1;                            // c4
      if (sb_wec === 1'b1) wec_seen++;
      tick(); uc_awready = 1'b0; uc_bvalid = 1'b1; sb_valid = 1'b0;   // c5
      if (sb_wec === 1'b1) wec_seen++;
      checks++;
      if (uc_bready !== 1'b1 || uc_awvalid !== 1'b0) begin
         failures++;
         $display("FAIL clr_u_resp: bready=%b awvalid=%b want 1/0", uc_bready, uc_awvalid);
      end
      tick(); uc_bvalid = 1'b0;                             // c6
      if (sb_wec === 1'b1) wec_seen++;
      tick();                                               // c7
      if (sb_wec === 1'b1) wec_seen++;
      checks++;
      if (wec_seen != 0 || dbg_state !== 3'd0 || busy !== 1'b0 || pending_cnt !== 3'd0) begin
         failures++;
         $display("FAIL clr_u_done: wec_pulses=%0d state=%0d busy=%b cnt=%0d want 0/0/0/0",
                  wec_seen, dbg_state, busy, pending_cnt);
      end
   endtask

   task automatic test_async_reset;
      set_head(32'h0000_3000, 4'hF, 32'h1111_2222, 1'b0);
      dc_ready = 1'b0; commit_store = 1'b1;
      tick(); commit_store = 1'b0;                          // c1
      tick();                                               // c2: C_REQ
      checks++;
      if (dc_req !== 1'b1) begin
         failures++;
         $display("FAIL areset_pre: dc_req=%b want 1", dc_req);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (dc_req !== 1'b0 || busy !== 1'b0 || pending_cnt !== 3'd0) begin
         failures++;
         $display("FAIL areset_now: req=%b busy=%b cnt=%0d want 0/0/0", dc_req, busy, pending_cnt);
      end
      idle_inputs();
      tick(); reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_cached_single();
      test_uncached_stall();
      test_bus_error();
      test_back_to_back();
      test_clear_cached();
      test_clear_uncached();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
